// File: rtl/bus_pkg.sv
// Shared definitions for the multiplexed address/data bus sequencer.
//   bus_state_t : sequencer FSM states
//   bus_op_t    : transfer opcode (read / write)
//   bus_pins_t  : registered external pin bundle plus status flags
//   pins_for()  : pin values that belong to a given state
package bus_pkg;

  localparam int WAIT_MAX = 3;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int BUS_W    = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    HOLD = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } bus_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } bus_op_t;

  typedef struct packed {
    logic             ale;
    logic             enb;
    logic             nme;
    logic             noe;
    logic             nwe;
    logic             busy;
    logic             ready;
    logic [BUS_W-1:0] adout;
  } bus_pins_t;

  // Pins are a pure function of the state being entered, so feeding this the
  // next state gives registered outputs with no extra cycle of delay.
  function automatic bus_pins_t pins_for(bus_state_t st, bus_op_t op,
                                         logic [BUS_W-1:0] addr,
                                         logic [BUS_W-1:0] wdata);
    bus_pins_t p;
    p.ale   = 1'b0;
    p.enb   = 1'b0;
    p.nme   = 1'b1;
    p.noe   = 1'b1;
    p.nwe   = 1'b1;
    p.busy  = 1'b1;
    p.ready = 1'b0;
    p.adout = '0;
    case (st)
      ADDR: begin
        p.ale   = 1'b1;
        p.enb   = 1'b1;
        p.adout = addr;
      end
      HOLD: begin
        p.enb   = 1'b1;
        p.nme   = 1'b0;
        p.adout = addr;
      end
      DATA: begin
        p.nme = 1'b0;
        if (op == OP_WRITE) begin
          p.enb   = 1'b1;
          p.nwe   = 1'b0;
          p.adout = wdata;
        end else begin
          p.noe = 1'b0;
        end
      end
      DONE:    p.ready = 1'b1;
      default: p.busy  = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Data-phase wait-state down counter.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (takes priority over dec)
//   dec       : decrement, saturating at zero
//   load_val  : value to load
//   zero      : count is zero
module wait_counter
  import bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WAIT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_sequencer.sv
// Sequencer for a multiplexed 16-bit address/data memory bus.
// A request captured in IDLE walks ADDR -> HOLD -> DATA (WaitStates+1 cycles)
// -> DONE -> IDLE. All pins are registered.
//   Clock, Reset            : clock, synchronous active-high reset
//   Req, Write, Addr, WData,
//   WaitStates              : transfer request and its parameters
//   ADIn                    : bus read path
//   ADOut, ENB              : bus drive value and output enable
//   ALE, nME, nOE, nWE      : memory strobes
//   RData                   : last completed read
//   Busy, Ready             : not-idle flag, one-cycle completion pulse
module bus_sequencer
  import bus_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Write,
  input  logic [BUS_W-1:0]  Addr,
  input  logic [BUS_W-1:0]  WData,
  input  logic [WAIT_W-1:0] WaitStates,
  input  logic [BUS_W-1:0]  ADIn,
  output logic [BUS_W-1:0]  ADOut,
  output logic              ENB,
  output logic              ALE,
  output logic              nME,
  output logic              nOE,
  output logic              nWE,
  output logic [BUS_W-1:0]  RData,
  output logic              Busy,
  output logic              Ready
);

  bus_state_t        state, state_nxt;
  bus_op_t           op_q, op_nxt;
  logic [BUS_W-1:0]  addr_q, addr_nxt;
  logic [BUS_W-1:0]  wdata_q, wdata_nxt;
  logic [WAIT_W-1:0] waits_q, waits_nxt;
  logic              cnt_load, cnt_dec, cnt_zero;
  bus_pins_t         pins_nxt;

  wait_counter u_wait (
    .clk      (Clock),
    .rst      (Reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (waits_q),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    waits_nxt = waits_q;
    case (state)
      IDLE: begin
        if (Req) begin
          state_nxt = ADDR;
          op_nxt    = Write ? OP_WRITE : OP_READ;
          addr_nxt  = Addr;
          wdata_nxt = WData;
          waits_nxt = WaitStates;
        end
      end
      ADDR:    state_nxt = HOLD;
      HOLD:    state_nxt = DATA;
      DATA:    if (cnt_zero) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Counter holds WaitStates during the first DATA cycle and reaches zero
    // on the last one.
    cnt_load = (state == HOLD);
    cnt_dec  = (state == DATA);
    pins_nxt = pins_for(state_nxt, op_nxt, addr_nxt, wdata_nxt);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      ALE   <= 1'b0;
      ENB   <= 1'b0;
      nME   <= 1'b1;
      nOE   <= 1'b1;
      nWE   <= 1'b1;
      Busy  <= 1'b0;
      Ready <= 1'b0;
      ADOut <= '0;
      RData <= '0;
    end else begin
      state <= state_nxt;
      {ALE, ENB, nME, nOE, nWE, Busy, Ready, ADOut} <= pins_nxt;
      if ((state == DATA) && cnt_zero && (op_q == OP_READ)) begin
        RData <= ADIn;
      end
    end
  end

  // Captured transfer parameters; only consulted while a transfer is active.
  always_ff @(posedge Clock) begin
    op_q    <= op_nxt;
    addr_q  <= addr_nxt;
    wdata_q <= wdata_nxt;
    waits_q <= waits_nxt;
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: transaction-level expectation queue checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_bus_sequencer;

  logic        Clock, Reset, Req, Write;
  logic [15:0] Addr, WData, ADIn, ADOut, RData;
  logic [1:0]  WaitStates;
  logic        ENB, ALE, nME, nOE, nWE, Busy, Ready;

  bus_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Write(Write), .Addr(Addr),
    .WData(WData), .WaitStates(WaitStates), .ADIn(ADIn), .ADOut(ADOut),
    .ENB(ENB), .ALE(ALE), .nME(nME), .nOE(nOE), .nWE(nWE), .RData(RData),
    .Busy(Busy), .Ready(Ready)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One expected cycle of pin activity.
  typedef struct packed {
    logic        ale, enb, nme, noe, nwe, busy, ready;
    logic [15:0] adout;
    logic        ld;   // RData takes ADIn at the edge starting this cycle
  } cyc_t;

  function automatic cyc_t mk(logic ale, logic enb, logic nme, logic noe, logic nwe,
                              logic busy, logic ready, logic [15:0] ad, logic ld);
    cyc_t c;
    c.ale = ale; c.enb = enb; c.nme = nme; c.noe = noe; c.nwe = nwe;
    c.busy = busy; c.ready = ready; c.adout = ad; c.ld = ld;
    return c;
  endfunction

  cyc_t        q[$];
  cyc_t        cur;
  logic [15:0] m_rdata;
  bit          m_valid = 0;
  logic        ready_prev = 1'b0;

  // Reference: an accepted request expands into its whole cycle list
  // (ADDR, HOLD, WaitStates+1 DATA, DONE, mandatory IDLE); no new request is
  // looked at until that list has drained.
  always @(posedge Clock) begin
    if (Reset) begin
      q.delete();
      cur     = mk(0, 0, 1, 1, 1, 0, 0, 16'h0, 0);
      m_rdata = 16'h0;
      m_valid = 1;
    end else if (m_valid) begin
      if (q.size() == 0 && Req) begin
        q.push_back(mk(1, 1, 1, 1, 1, 1, 0, Addr, 0));
        q.push_back(mk(0, 1, 0, 1, 1, 1, 0, Addr, 0));
        for (int i = 0; i <= int'(WaitStates); i++)
          q.push_back(Write ? mk(0, 1, 0, 1, 0, 1, 0, WData, 0)
                            : mk(0, 0, 0, 0, 1, 1, 0, 16'h0, 0));
        q.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'h0, !Write));
        q.push_back(mk(0, 0, 1, 1, 1, 0, 0, 16'h0, 0));
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = mk(0, 0, 1, 1, 1, 0, 0, 16'h0, 0);
      if (cur.ld) m_rdata = ADIn;
    end
  end

  always @(negedge Clock) begin
    if (m_valid) begin
      chk("pins_vs_model", {ALE, ENB, nME, nOE, nWE, Busy, Ready, ADOut, RData},
          {cur.ale, cur.enb, cur.nme, cur.noe, cur.nwe, cur.busy, cur.ready, cur.adout, m_rdata});
      chk("noe_nwe_both_low", 64'(!nOE && !nWE), 64'd0);
      chk("ale_while_nme_low", 64'(ALE && !nME), 64'd0);
      chk("adout_nonzero_enb0", 64'(!ENB && (ADOut != 16'h0)), 64'd0);
      chk("ready_not_pulse", 64'(Ready && ready_prev), 64'd0);
      ready_prev = Ready;
    end
  end

  // Issue one request, change every captured input right after acceptance,
  // then watch 12 cycles (cycle 1 = ADDR).
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [15:0] a_after,
                      input logic [15:0] wd, input logic [1:0] ws,
                      output int ready_at, output int ale_n, output int noe_n,
                      output int nwe_n, output int bad);
    Write = wr; Addr = a; WData = wd; WaitStates = ws; Req = 1'b1;
    @(posedge Clock); #1;
    Req = 1'b0; Addr = a_after; WData = ~wd; Write = ~wr; WaitStates = ~ws;
    ready_at = -1; ale_n = 0; noe_n = 0; nwe_n = 0; bad = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clock);
      if (ALE) ale_n++;
      if (!nOE) noe_n++;
      if (!nWE) begin
        nwe_n++;
        if (!ENB || ADOut !== wd) bad++;
      end
      if (c <= 2 && (!ENB || ADOut !== a)) bad++;
      if (c == 1 && !ALE) bad++;
      if (Ready && ready_at < 0) ready_at = c;
    end
  endtask

  int ra, an, on, wn, bd, nrdy;
  int rpos[3];

  initial begin
    Reset = 1'b1; Req = 1'b0; Write = 1'b0; Addr = 16'h0; WData = 16'h0;
    WaitStates = 2'd0; ADIn = 16'h0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("reset_state", {ALE, ENB, nME, nOE, nWE, Busy, Ready, ADOut, RData},
        {7'b0011100, 16'h0, 16'h0});
    @(posedge Clock); #1;
    Reset = 1'b0;

    // Read, no wait states.
    ADIn = 16'hBEEF;
    xfer(1'b0, 16'h0040, 16'h5555, 16'h0000, 2'd0, ra, an, on, wn, bd);
    chk("rd0_ready_cycle", ra, 4);
    chk("rd0_ale_cycles", an, 1);
    chk("rd0_noe_cycles", on, 1);
    chk("rd0_nwe_cycles", wn, 0);
    chk("rd0_adout", bd, 0);
    chk("rd0_rdata", RData, 16'hBEEF);

    // Write, three wait states.
    xfer(1'b1, 16'h1234, 16'h4321, 16'hA5A5, 2'd3, ra, an, on, wn, bd);
    chk("wr3_ready_cycle", ra, 7);
    chk("wr3_nwe_cycles", wn, 4);
    chk("wr3_noe_cycles", on, 0);
    chk("wr3_adout", bd, 0);
    chk("wr3_rdata_kept", RData, 16'hBEEF);

    // Address changed after acceptance.
    ADIn = 16'h7E57;
    xfer(1'b0, 16'h0001, 16'hFFFF, 16'h0000, 2'd1, ra, an, on, wn, bd);
    chk("addrchg_adout", bd, 0);
    chk("addrchg_ready_cycle", ra, 5);
    chk("addrchg_rdata", RData, 16'h7E57);

    // Req held for three transfers.
    Write = 1'b0; Addr = 16'h0100; WaitStates = 2'd1; Req = 1'b1;
    @(posedge Clock); #1;
    nrdy = 0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge Clock);
      if (Ready) begin
        if (nrdy < 3) rpos[nrdy] = c;
        nrdy++;
      end
    end
    Req = 1'b0;
    chk("b2b_ready_count", nrdy, 3);
    chk("b2b_first_ready", rpos[0], 5);
    chk("b2b_gap1", rpos[1] - rpos[0], 6);
    chk("b2b_gap2", rpos[2] - rpos[1], 6);

    // Reset during the data phase of a read.
    repeat (3) @(negedge Clock);
    ADIn = 16'h0F0F;
    xfer(1'b0, 16'h0200, 16'h0200, 16'h0000, 2'd0, ra, an, on, wn, bd);
    chk("pre_rdata", RData, 16'h0F0F);
    ADIn = 16'h1111;
    Write = 1'b0; Addr = 16'h0300; WaitStates = 2'd3; Req = 1'b1;
    @(posedge Clock); #1;
    Req = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_in_data_noe", nOE, 1'b0);
    chk("rst_in_data_rdata", RData, 16'h0F0F);
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_abort_state", {ALE, ENB, nME, nOE, nWE, Busy, Ready, ADOut, RData},
        {7'b0011100, 16'h0, 16'h0});
    nrdy = 0;
    repeat (6) begin
      @(negedge Clock);
      if (Ready) nrdy++;
    end
    chk("rst_abort_no_ready", nrdy, 0);
    chk("rst_abort_rdata", RData, 16'h0);

    // Random traffic with occasional resets.
    repeat (2000) begin
      @(posedge Clock); #1;
      Reset      = ($urandom_range(0, 99) == 0);
      Req        = ($urandom_range(0, 2) != 0);
      Write      = 1'($urandom);
      Addr       = 16'($urandom);
      WData      = 16'($urandom);
      ADIn       = 16'($urandom);
      WaitStates = 2'($urandom);
    end
    @(posedge Clock); #1;
    Reset = 1'b0; Req = 1'b0;
    repeat (10) @(posedge Clock);
    @(negedge Clock);
    chk("final_idle_busy", Busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
